cfu_dot_sequencer: RTL and testbench

//  Sequencer between the CPU CFU port and a shared int4/int8 MAC datapath.
//  - CPU pushes packed operand pairs into a small FIFO, loads a bias, then issues RUN.
//  - Block drains the FIFO through the MAC one pair at a time and accumulates the partial sums.
//  - It then applies bias, quantise shift, optional ReLU and clamp, and answers RUN with the result.

---
 rtl/cfu_pkg.sv | 21 ++
 rtl/cfu_operand_fifo.sv | 77 +++++++
 rtl/cfu_dot_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cfu_dot_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_pkg.sv
// Shared opcodes, FSM state encoding and response constants for the CFU dot-product sequencer.
package cfu_pkg;

  localparam logic [2:0] OP_PUSH     = 3'b000;
  localparam logic [2:0] OP_BIAS     = 3'b001;
  localparam logic [2:0] OP_RUN      = 3'b010;
  localparam logic [2:0] OP_RUN_RELU = 3'b011;
  localparam logic [2:0] OP_STATUS   = 3'b100;
  localparam logic [2:0] OP_CLEAR    = 3'b101;

  localparam logic [31:0] FULL_RESP = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINAL,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cfu_operand_fifo.sv
// First-word-fall-through operand FIFO holding packed {rs1, rs2} pairs.
module cfu_operand_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = i_push && !o_full;
    do_pop   = i_pop && !o_empty;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = i_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cfu_dot_sequencer.sv
// CFU-facing sequencer: queues operand pairs, streams them through a shared MAC,
// then biases, quantises, optionally ReLUs and clamps the accumulated sum.
module cfu_dot_sequencer
  import cfu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int SHIFT = 5,
  parameter int QMIN  = -8,
  parameter int QMAX  = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfu_valid,
  input  logic [2:0]       i_cfu_op,
  input  logic [WIDTH-1:0] i_cfu_rs1,
  input  logic [WIDTH-1:0] i_cfu_rs2,
  output logic             o_cfu_ready,
  output logic [WIDTH-1:0] o_cfu_rd,
  output logic             o_mac_valid,
  output logic [WIDTH-1:0] o_mac_a,
  output logic [WIDTH-1:0] o_mac_b,
  input  logic             i_mac_ready,
  input  logic             i_mac_rvalid,
  input  logic [WIDTH-1:0] i_mac_sum,
  output logic             o_busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic signed [WIDTH-1:0] QMIN_W = WIDTH'(QMIN);
  localparam logic signed [WIDTH-1:0] QMAX_W = WIDTH'(QMAX);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] bias_q, bias_d;
  logic                    relu_q, relu_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]        resp_data_q, resp_data_d;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_flush;
  logic [2*WIDTH-1:0]      fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;

  logic                    busy;
  logic                    cmd_fire;
  logic signed [WIDTH-1:0] sum_biased;
  logic signed [WIDTH-1:0] sum_relu;
  logic signed [WIDTH-1:0] sum_shift;
  logic signed [WIDTH-1:0] clamped;

  cfu_operand_fifo #(
    .DATA_W (2*WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_data  ({i_cfu_rs1, i_cfu_rs2}),
    .i_pop   (fifo_pop),
    .i_flush (fifo_flush),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // A command held across its own response strobe must not be taken twice.
  assign busy        = (state_q != ST_IDLE);
  assign cmd_fire    = (state_q == ST_IDLE) && i_cfu_valid && !resp_valid_q;
  assign o_busy      = busy;
  assign o_cfu_ready = resp_valid_q;
  assign o_cfu_rd    = resp_valid_q ? resp_data_q : '0;

  always_comb begin
    sum_biased = acc_q + bias_q;
    sum_relu   = (relu_q && sum_biased[WIDTH-1]) ? '0 : sum_biased;
    sum_shift  = sum_relu >>> SHIFT;
    if (sum_shift < QMIN_W) begin
      clamped = QMIN_W;
    end else if (sum_shift > QMAX_W) begin
      clamped = QMAX_W;
    end else begin
      clamped = sum_shift;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    bias_d       = bias_q;
    relu_d       = relu_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    o_mac_valid  = 1'b0;
    o_mac_a      = '0;
    o_mac_b      = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (i_cfu_op)
            OP_PUSH: begin
              resp_valid_d = 1'b1;
              if (!fifo_full) begin
                fifo_push   = 1'b1;
                resp_data_d = WIDTH'(fifo_count) + WIDTH'(1);
              end else begin
                resp_data_d = WIDTH'(FULL_RESP);
              end
            end
            OP_BIAS: begin
              bias_d       = i_cfu_rs1;
              resp_valid_d = 1'b1;
            end
            OP_RUN, OP_RUN_RELU: begin
              acc_d   = '0;
              relu_d  = i_cfu_op[0];
              state_d = fifo_empty ? ST_FINAL : ST_ISSUE;
            end
            OP_STATUS: begin
              resp_valid_d = 1'b1;
              resp_data_d  = WIDTH'({16'(fifo_count), 15'b0, busy});
            end
            OP_CLEAR: begin
              fifo_flush   = 1'b1;
              acc_d        = '0;
              bias_d       = '0;
              resp_valid_d = 1'b1;
            end
            default: begin
              resp_valid_d = 1'b1;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        o_mac_valid = 1'b1;
        o_mac_a     = fifo_head[2*WIDTH-1:WIDTH];
        o_mac_b     = fifo_head[WIDTH-1:0];
        if (i_mac_ready) begin
          fifo_pop = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      // The head was popped on accept, so empty here means this was the last pair.
      ST_WAIT: begin
        if (i_mac_rvalid) begin
          acc_d   = acc_q + $signed(i_mac_sum);
          state_d = fifo_empty ? ST_FINAL : ST_ISSUE;
        end
      end
      ST_FINAL: begin
        resp_valid_d = 1'b1;
        resp_data_d  = clamped;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      bias_q       <= '0;
      relu_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bias_q       <= bias_d;
      relu_q       <= relu_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_cfu_dot_sequencer.sv
// Directed bench for cfu_dot_sequencer with a behavioural MAC and hand-computed results.
module tb_cfu_dot_sequencer;

  localparam int WIDTH = 32;
  localparam logic [2:0] C_PUSH     = 3'b000;
  localparam logic [2:0] C_BIAS     = 3'b001;
  localparam logic [2:0] C_RUN      = 3'b010;
  localparam logic [2:0] C_RUN_RELU = 3'b011;
  localparam logic [2:0] C_STATUS   = 3'b100;
  localparam logic [2:0] C_CLEAR    = 3'b101;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_cfu_valid = 1'b0;
  logic [2:0]       i_cfu_op = '0;
  logic [WIDTH-1:0] i_cfu_rs1 = '0;
  logic [WIDTH-1:0] i_cfu_rs2 = '0;
  logic             o_cfu_ready;
  logic [WIDTH-1:0] o_cfu_rd;
  logic             o_mac_valid;
  logic [WIDTH-1:0] o_mac_a;
  logic [WIDTH-1:0] o_mac_b;
  logic             i_mac_ready = 1'b0;
  logic             i_mac_rvalid = 1'b0;
  logic [WIDTH-1:0] i_mac_sum = '0;
  logic             o_busy;

  int assert_count = 0;
  int fail_count   = 0;

  logic             mac_ready_en = 1'b1;
  int               mac_lat = 1;
  int               mac_req_count = 0;
  logic [31:0]      mac_sums[$];
  logic [31:0]      mac_a_log[$];
  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic             prev_rst = 1'b0;
  logic [31:0]      prev_a = '0;
  int               countdown = 0;
  logic [31:0]      pending_sum = '0;

  always #5 clk = ~clk;

  cfu_dot_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (8),
    .SHIFT (5),
    .QMIN  (-8),
    .QMAX  (7)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfu_valid  (i_cfu_valid),
    .i_cfu_op     (i_cfu_op),
    .i_cfu_rs1    (i_cfu_rs1),
    .i_cfu_rs2    (i_cfu_rs2),
    .o_cfu_ready  (o_cfu_ready),
    .o_cfu_rd     (o_cfu_rd),
    .o_mac_valid  (o_mac_valid),
    .o_mac_a      (o_mac_a),
    .o_mac_b      (o_mac_b),
    .i_mac_ready  (i_mac_ready),
    .i_mac_rvalid (i_mac_rvalid),
    .i_mac_sum    (i_mac_sum),
    .o_busy       (o_busy)
  );

  // Behavioural MAC: an accept seen at one edge returns the next queued sum mac_lat cycles later.
  always @(negedge clk) begin
    i_mac_rvalid = 1'b0;
    i_mac_sum    = '0;
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        i_mac_rvalid = 1'b1;
        i_mac_sum    = pending_sum;
      end
    end
    if (prev_valid && prev_ready && prev_rst) begin
      mac_req_count++;
      mac_a_log.push_back(prev_a);
      pending_sum = '0;
      if (mac_sums.size() > 0) pending_sum = mac_sums.pop_front();
      countdown = mac_lat;
    end
    i_mac_ready = mac_ready_en;
    prev_valid  = o_mac_valid;
    prev_ready  = i_mac_ready;
    prev_rst    = rst_n;
    prev_a      = o_mac_a;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic waitResponse(output logic [31:0] rd, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    rd     = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      cycles++;
      if (o_cfu_ready) begin
        got = 1'b1;
        rd  = o_cfu_rd;
      end
    end
    i_cfu_valid = 1'b0;
    i_cfu_op    = '0;
    if (!got) checkOutput("response_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                               output logic [31:0] rd, output int cycles);
    i_cfu_valid = 1'b1;
    i_cfu_op    = op;
    i_cfu_rs1   = rs1;
    i_cfu_rs2   = rs2;
    waitResponse(rd, cycles);
  endtask

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          base;
    bit          seen;
    int          ready_seen;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(o_cfu_ready), 32'd0);
    checkOutput("reset_rd", o_cfu_rd, 32'd0);
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_mac_valid", 32'(o_mac_valid), 32'd0);
    checkOutput("reset_mac_a", o_mac_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] scenario 1: bias 4, two pairs, sums 100 and 60");
    applyStimulus(C_BIAS, 32'd4, 32'd0, rd, cyc);
    checkOutput("s1_bias_rd", rd, 32'd0);
    applyStimulus(C_PUSH, 32'hA1, 32'hB1, rd, cyc);
    checkOutput("s1_push1_rd", rd, 32'd1);
    checkOutput("s1_push_latency", 32'(cyc), 32'd1);
    applyStimulus(C_PUSH, 32'hA2, 32'hB2, rd, cyc);
    checkOutput("s1_push2_rd", rd, 32'd2);
    mac_sums.push_back(32'd100);
    mac_sums.push_back(32'd60);
    mac_a_log.delete();
    base = mac_req_count;
    applyStimulus(C_RUN, 32'd0, 32'd0, rd, cyc);
    checkOutput("s1_run_rd", rd, 32'd5);
    checkOutput("s1_mac_reqs", 32'(mac_req_count - base), 32'd2);
    checkOutput("s1_first_a", (mac_a_log.size() > 0) ? mac_a_log[0] : 32'hDEAD_BEEF, 32'hA1);
    checkOutput("idle_rd_zero", o_cfu_rd, 32'd0);
    checkOutput("idle_mac_a_zero", o_mac_a, 32'd0);

    $display("[TB] scenario 2: negative sum with and without ReLU");
    applyStimulus(C_PUSH, 32'h1, 32'h2, rd, cyc);
    checkOutput("s2_push_rd", rd, 32'd1);
    applyStimulus(C_BIAS, 32'd0, 32'd0, rd, cyc);
    mac_sums.push_back(32'(-300));
    applyStimulus(C_RUN_RELU, 32'd0, 32'd0, rd, cyc);
    checkOutput("s2_relu_rd", rd, 32'd0);
    applyStimulus(C_PUSH, 32'h1, 32'h2, rd, cyc);
    mac_sums.push_back(32'(-300));
    applyStimulus(C_RUN, 32'd0, 32'd0, rd, cyc);
    checkOutput("s2_run_neg_clamp", rd, 32'hFFFF_FFF8);

    $display("[TB] scenario 3: upper clamp and empty run");
    applyStimulus(C_BIAS, 32'd0, 32'd0, rd, cyc);
    applyStimulus(C_PUSH, 32'h5, 32'h6, rd, cyc);
    mac_sums.push_back(32'd1000);
    applyStimulus(C_RUN, 32'd0, 32'd0, rd, cyc);
    checkOutput("s3_run_clamp_hi", rd, 32'd7);
    applyStimulus(C_BIAS, 32'd1000, 32'd0, rd, cyc);
    base = mac_req_count;
    applyStimulus(C_RUN, 32'd0, 32'd0, rd, cyc);
    checkOutput("s3_empty_run_rd", rd, 32'd7);
    checkOutput("s3_empty_run_cycles", 32'(cyc + 1), 32'd3);
    checkOutput("s3_empty_run_no_mac", 32'(mac_req_count - base), 32'd0);

    $display("[TB] scenario 4: overfill, status, eight-pair run");
    applyStimulus(C_CLEAR, 32'd0, 32'd0, rd, cyc);
    checkOutput("s4_clear_rd", rd, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(C_PUSH, 32'(i), 32'(i + 16), rd, cyc);
      checkOutput($sformatf("s4_push%0d_rd", i), rd, (i <= 8) ? 32'(i) : 32'hFFFF_FFFF);
    end
    applyStimulus(C_STATUS, 32'd0, 32'd0, rd, cyc);
    checkOutput("s4_status_full", rd, 32'h0008_0000);
    for (int i = 1; i <= 8; i++) mac_sums.push_back(32'(i));
    mac_a_log.delete();
    base = mac_req_count;
    applyStimulus(C_RUN, 32'd0, 32'd0, rd, cyc);
    checkOutput("s4_run_rd", rd, 32'd1);
    checkOutput("s4_mac_reqs", 32'(mac_req_count - base), 32'd8);
    checkOutput("s4_last_a", (mac_a_log.size() == 8) ? mac_a_log[7] : 32'hDEAD_BEEF, 32'd8);
    applyStimulus(C_STATUS, 32'd0, 32'd0, rd, cyc);
    checkOutput("s4_status_empty", rd, 32'd0);

    $display("[TB] scenario 5: MAC stalls for five cycles");
    applyStimulus(C_PUSH, 32'h11, 32'h22, rd, cyc);
    applyStimulus(C_PUSH, 32'h33, 32'h44, rd, cyc);
    checkOutput("s5_push2_rd", rd, 32'd2);
    mac_ready_en = 1'b0;
    @(negedge clk);
    mac_sums.push_back(32'd32);
    mac_sums.push_back(32'd64);
    mac_a_log.delete();
    base = mac_req_count;
    i_cfu_valid = 1'b1;
    i_cfu_op    = C_RUN;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_mac_valid) seen = 1'b1;
    end
    checkOutput("s5_issue_reached", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("s5_stall%0d_valid", i), 32'(o_mac_valid), 32'd1);
      checkOutput($sformatf("s5_stall%0d_a", i), o_mac_a, 32'h11);
      checkOutput($sformatf("s5_stall%0d_b", i), o_mac_b, 32'h22);
      @(negedge clk);
    end
    checkOutput("s5_no_accept_yet", 32'(mac_req_count - base), 32'd0);
    mac_ready_en = 1'b1;
    waitResponse(rd, cyc);
    checkOutput("s5_run_rd", rd, 32'd3);
    checkOutput("s5_mac_reqs", 32'(mac_req_count - base), 32'd2);
    checkOutput("s5_second_a", (mac_a_log.size() == 2) ? mac_a_log[1] : 32'hDEAD_BEEF, 32'h33);

    $display("[TB] scenario 6: reset while waiting on the MAC");
    applyStimulus(C_PUSH, 32'h77, 32'h88, rd, cyc);
    mac_lat = 4;
    mac_sums.push_back(32'd500);
    i_cfu_valid = 1'b1;
    i_cfu_op    = C_RUN;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_mac_valid) seen = 1'b1;
    end
    checkOutput("s6_issue_reached", 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput("s6_in_wait_busy", 32'(o_busy), 32'd1);
    checkOutput("s6_in_wait_mac_valid", 32'(o_mac_valid), 32'd0);
    rst_n       = 1'b0;
    i_cfu_valid = 1'b0;
    i_cfu_op    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("s6_reset_busy", 32'(o_busy), 32'd0);
    ready_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_cfu_ready) ready_seen++;
    end
    checkOutput("s6_no_response", 32'(ready_seen), 32'd0);
    checkOutput("s6_idle_after_late_rvalid", 32'(o_busy), 32'd0);
    applyStimulus(C_STATUS, 32'd0, 32'd0, rd, cyc);
    checkOutput("s6_status", rd, 32'd0);
    mac_lat = 1;
    applyStimulus(C_PUSH, 32'h9, 32'hA, rd, cyc);
    checkOutput("s6_push_rd", rd, 32'd1);
    mac_sums.push_back(32'd64);
    applyStimulus(C_RUN, 32'd0, 32'd0, rd, cyc);
    checkOutput("s6_run_rd", rd, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
